// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with EX-stage forwarding and ALU operand select
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic [XLEN-1:0]    RD1D,
  input  logic [XLEN-1:0]    RD2D,
  input  logic [XLEN-1:0]    ImmExtD,
  input  logic [XLEN-1:0]    PCD,
  input  logic [XLEN-1:0]    PCPlus4D,
  input  logic [REGADDR-1:0] Rs1D,
  input  logic [REGADDR-1:0] Rs2D,
  input  logic [REGADDR-1:0] RdD,
  input  logic [3:0]         ALUControlD,
  input  logic [1:0]         ALUSrcAD,
  input  logic               ALUSrcBD,
  input  logic               RegWriteD,
  input  logic               MemWriteD,
  input  logic               BranchD,
  input  logic               JumpD,
  input  logic [1:0]         ResultSrcD,
  input  logic [REGADDR-1:0] RdM,
  input  logic [REGADDR-1:0] RdW,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic [XLEN-1:0]    ALUResultM,
  input  logic [XLEN-1:0]    ResultW,
  output logic [XLEN-1:0]    SrcAE,
  output logic [XLEN-1:0]    SrcBE,
  output logic [3:0]         ALUControlE,
  output logic [XLEN-1:0]    WriteDataE,
  output logic [REGADDR-1:0] Rs1E,
  output logic [REGADDR-1:0] Rs2E,
  output logic [REGADDR-1:0] RdE,
  output logic [XLEN-1:0]    PCE,
  output logic [XLEN-1:0]    PCPlus4E,
  output logic [XLEN-1:0]    ImmExtE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               BranchE,
  output logic               JumpE,
  output logic [1:0]         ResultSrcE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE
);
  typedef struct packed {
    logic [XLEN-1:0]    rd1, rd2, imm, pc, pc4;
    logic [REGADDR-1:0] rs1, rs2, rd;
    logic [3:0]         aluc;
    logic [1:0]         srca;
    logic               srcb, rw, mw, br, j;
    logic [1:0]         res;
  } ex_t;
  ex_t d_in, e_d, e_q;
  logic [XLEN-1:0] reg_a, reg_b;
  assign d_in = '{rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD, pc4: PCPlus4D,
                  rs1: Rs1D, rs2: Rs2D, rd: RdD, aluc: ALUControlD, srca: ALUSrcAD,
                  srcb: ALUSrcBD, rw: RegWriteD, mw: MemWriteD, br: BranchD, j: JumpD,
                  res: ResultSrcD};
  // Next E state: a flush loads an all-zero bubble and wins over a stall
  always_comb e_d = FlushE ? '0 : StallE ? e_q : d_in;
  // E register bank; async reset also leaves a bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) e_q <= '0;
    else e_q <= e_d;
  // Forward selects: MEM beats WB, x0 is never forwarded; operands then muxed for the ALU
  always_comb begin
    ForwardAE = (RegWriteM && RdM != '0 && RdM == e_q.rs1) ? 2'b10 :
                (RegWriteW && RdW != '0 && RdW == e_q.rs1) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && RdM != '0 && RdM == e_q.rs2) ? 2'b10 :
                (RegWriteW && RdW != '0 && RdW == e_q.rs2) ? 2'b01 : 2'b00;
    reg_a = ForwardAE[1] ? ALUResultM : ForwardAE[0] ? ResultW : e_q.rd1;
    reg_b = ForwardBE[1] ? ALUResultM : ForwardBE[0] ? ResultW : e_q.rd2;
    SrcAE = e_q.srca == 2'b00 ? reg_a : e_q.srca == 2'b01 ? e_q.pc : '0;
    SrcBE = e_q.srcb ? e_q.imm : reg_b;
  end
  assign WriteDataE  = reg_b;
  assign ALUControlE = e_q.aluc;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc4;
  assign ImmExtE     = e_q.imm;
  assign RegWriteE   = e_q.rw;
  assign MemWriteE   = e_q.mw;
  assign BranchE     = e_q.br;
  assign JumpE       = e_q.j;
  assign ResultSrcE  = e_q.res;
endmodule
